// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared types and reset constants for the serial sequence detector
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Width of the cfg_len field
    localparam int CFG_LEN_W = 4;

    // Configuration loaded by reset
    localparam logic [3:0]           RST_PATTERN = 4'b0101;
    localparam logic [CFG_LEN_W-1:0] RST_LEN     = 4'd4;

    // Controller FSM states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Lengths beyond the history depth compare the whole history instead
    function automatic logic [CFG_LEN_W-1:0] clamp_len(input logic [CFG_LEN_W-1:0] len,
                                                       input int max_len);
        if (int'(len) > max_len) begin
            return CFG_LEN_W'(max_len);
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pattern_matcher.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_matcher
// Brief    : Bit history shift register, valid-bit counter and masked compare
// Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_matcher
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic [PAT_MAX-1:0]   pattern,
    input  logic [CFG_LEN_W-1:0] len,
    input  logic                 clear,
    output logic                 match,
    output logic                 match_next
);

    localparam int VCNT_W = $clog2(PAT_MAX + 1);

    logic [PAT_MAX-1:0] hist_q;
    logic [PAT_MAX-1:0] hist_d;
    logic [VCNT_W-1:0]  vcnt_q;
    logic [VCNT_W-1:0]  vcnt_d;
    logic [PAT_MAX-1:0] mask;
    logic               hit;
    logic               match_q;

    // Next history (newest bit at [0]) and compare against the post-push window
    always_comb begin
        hist_d = hist_q;
        vcnt_d = vcnt_q;
        mask   = '0;
        if (bit_valid) begin
            hist_d = {hist_q[PAT_MAX-2:0], bit_in};
            if (vcnt_q != VCNT_W'(PAT_MAX)) begin
                vcnt_d = vcnt_q + 1'b1;
            end
        end
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = bit_valid && (len != '0) && (int'(vcnt_d) >= int'(len)) &&
              (((hist_d ^ pattern) & mask) == '0);
    end

    // History, fill level and registered match; clear restarts the fill count
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist_q  <= '0;
            vcnt_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            vcnt_q  <= vcnt_d;
            match_q <= hit;
        end
    end

    assign match      = match_q;
    assign match_next = hit;

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_ctrl
// Brief    : Word serializer, config, match counter and sticky irq around
//            a programmable serial pattern matcher
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int WORD_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_wr,
    input  logic [PAT_MAX-1:0]   cfg_pattern,
    input  logic [CFG_LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0]     cfg_thresh,
    output logic                 cfg_err,
    input  logic                 in_valid,
    input  logic [WORD_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 det_pulse,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 irq,
    input  logic                 irq_clr
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t                 state_q;
    logic [WORD_W-1:0]      data_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   cfg_err_q;
    logic [PAT_MAX-1:0]     pattern_q;
    logic [CFG_LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]       thresh_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   irq_q;
    logic                   irq_set;

    logic                   accept;
    logic                   cfg_ok;
    logic                   bit_valid;
    logic                   bit_in;
    logic                   match_next;

    // A config write only lands when the serializer is idle and not starting a word
    assign accept    = in_valid && in_ready_q;
    assign cfg_ok    = cfg_wr && (state_q == ST_IDLE) && !accept;
    assign bit_valid = (state_q == ST_SHIFT);
    assign bit_in    = data_q[bit_idx_q];

    // Serializer FSM: accept a word in IDLE, then push it MSB-first one bit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            bit_idx_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q     <= in_data;
                        bit_idx_q  <= IDX_W'(WORD_W - 1);
                        state_q    <= ST_SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_idx_q == '0) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        bit_idx_q <= bit_idx_q - 1'b1;
                    end
                end
            endcase
        end
    end

    // Configuration registers and the dropped-write error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= PAT_MAX'(RST_PATTERN);
            len_q     <= RST_LEN;
            thresh_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_wr && !cfg_ok;
            if (cfg_ok) begin
                pattern_q <= cfg_pattern;
                len_q     <= clamp_len(cfg_len, PAT_MAX);
                thresh_q  <= cfg_thresh;
            end
        end
    end

    // Saturating match count; irq fires when the count steps onto a non-zero threshold
    always_comb begin
        cnt_d   = cnt_q;
        irq_set = 1'b0;
        if (match_next && (cnt_q != '1)) begin
            cnt_d   = cnt_q + 1'b1;
            irq_set = (thresh_q != '0) && (cnt_d == thresh_q);
        end
    end

    // Counter and sticky irq; a set on the same edge as a clear takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cnt_q <= cfg_ok ? '0 : cnt_d;
            irq_q <= irq_set || (irq_q && !irq_clr);
        end
    end

    seq_pattern_matcher #(
        .PAT_MAX (PAT_MAX)
    ) u_matcher (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .pattern    (pattern_q),
        .len        (len_q),
        .clear      (cfg_ok),
        .match      (det_pulse),
        .match_next (match_next)
    );

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;
    assign match_cnt = cnt_q;
    assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_ctrl
// Brief    : Directed self-checking bench for seq_detect_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [15:0] cfg_thresh;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        irq_clr;

    logic        cfg_err, in_ready, busy, det_pulse, irq;
    logic [15:0] match_cnt;

    logic        s_cfg_err, s_in_ready, s_busy, s_det_pulse, s_irq;
    logic [3:0]  s_match_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .det_pulse(det_pulse), .match_cnt(match_cnt), .irq(irq), .irq_clr(irq_clr)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation
    seq_detect_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_thresh(cfg_thresh[3:0]), .cfg_err(s_cfg_err),
        .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready), .busy(s_busy),
        .det_pulse(s_det_pulse), .match_cnt(s_match_cnt), .irq(s_irq), .irq_clr(irq_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends one word starting at a negedge; trace bit j = sample at the j-th negedge
    // after the accepting edge. cfg_j/clr_j pick the trace slot after which cfg_wr /
    // irq_clr is raised for one cycle (cfg_j = -1 raises cfg_wr with the handshake).
    task automatic send_word(input logic [7:0] d, input int cfg_j, input int clr_j,
                             output logic [8:0] pulses, output logic [8:0] irqs,
                             output logic [8:0] errs, output int rdy_low);
        pulses   = '0;
        irqs     = '0;
        errs     = '0;
        rdy_low  = 0;
        in_valid = 1'b1;
        in_data  = d;
        cfg_wr   = (cfg_j < 0);
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j == 0) in_valid = 1'b0;
            pulses[j] = det_pulse;
            irqs[j]   = irq;
            errs[j]   = cfg_err;
            if (!in_ready) rdy_low++;
            cfg_wr  = (j == cfg_j);
            irq_clr = (j == clr_j);
        end
        cfg_wr  = 1'b0;
        irq_clr = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic [15:0] t);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_thresh  = t;
        cfg_wr      = 1'b1;
        @(negedge clk);
        cfg_wr      = 1'b0;
    endtask

    logic [8:0] pulses, irqs, errs;
    int         rdy_low;

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
        in_valid = 1'b0; in_data = '0; irq_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_det_pulse", det_pulse, 0);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_irq", irq, 0);
        check("rst_cfg_err", cfg_err, 0);

        // Default pattern 0101: 0x55 matches after bits 4, 6, 8
        send_word(8'h55, 99, 99, pulses, irqs, errs, rdy_low);
        check("w1_pulses", pulses, 9'h150);
        check("w1_ready_low", rdy_low, 8);
        check("w1_cnt", match_cnt, 3);
        check("w1_busy_end", busy, 0);

        // Back-to-back word, pattern spans the word boundary
        send_word(8'h55, 99, 99, pulses, irqs, errs, rdy_low);
        check("w2_pulses", pulses, 9'h154);
        check("w2_cnt", match_cnt, 7);

        // Pattern 111 len 3, threshold 2; clear coincides with the setting edge
        cfg_write(8'h07, 4'd3, 16'd2);
        check("cfg3_err", cfg_err, 0);
        check("cfg3_cnt_clr", match_cnt, 0);
        send_word(8'hFF, 99, 3, pulses, irqs, errs, rdy_low);
        check("w3_pulses", pulses, 9'h1F8);
        check("w3_irq_trace", irqs, 9'h1F0);
        check("w3_cnt", match_cnt, 6);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("w3_irq_cleared", irq, 0);

        // Config write mid-shift is dropped and flagged; old pattern keeps matching
        cfg_pattern = 8'h05; cfg_len = 4'd4; cfg_thresh = 16'd0;
        send_word(8'hF0, 2, 99, pulses, irqs, errs, rdy_low);
        check("w4_err_trace", errs, 9'h008);
        check("w4_pulses", pulses, 9'h01E);
        check("w4_cnt", match_cnt, 10);
        send_word(8'h07, 99, 99, pulses, irqs, errs, rdy_low);
        check("w4b_pulses", pulses, 9'h100);
        check("w4b_cnt", match_cnt, 11);
        // Config write coincident with the accepting handshake is dropped too
        send_word(8'hE0, -1, 99, pulses, irqs, errs, rdy_low);
        check("w4c_err_trace", errs, 9'h001);
        check("w4c_pulses", pulses, 9'h00E);
        check("w4c_cnt", match_cnt, 14);
        check("w4c_irq", irq, 0);

        // Length 0 disables matching
        cfg_write(8'h00, 4'd0, 16'd0);
        check("cfg5_cnt_clr", match_cnt, 0);
        send_word(8'h00, 99, 99, pulses, irqs, errs, rdy_low);
        check("w5_len0_pulses", pulses, 9'h000);
        check("w5_len0_cnt", match_cnt, 0);

        // Length 12 clamps to an 8-bit compare
        cfg_write(8'hA5, 4'd12, 16'd0);
        send_word(8'hA5, 99, 99, pulses, irqs, errs, rdy_low);
        check("w5_len12_pulses", pulses, 9'h100);
        check("w5_len12_cnt", match_cnt, 1);

        // Reset on the edge that would complete a 0101 match
        cfg_write(8'h05, 4'd4, 16'd0);
        in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst6_in_ready", in_ready, 1);
        check("rst6_busy", busy, 0);
        check("rst6_cnt", match_cnt, 0);
        check("rst6_det_pulse", det_pulse, 0);
        @(negedge clk);
        check("rst6_det_after", det_pulse, 0);
        check("rst6_busy_after", busy, 0);

        // Saturation: six 0x55 words give 23 matches; the 4-bit counter stops at 15
        for (int w = 0; w < 6; w++) begin
            send_word(8'h55, 99, 99, pulses, irqs, errs, rdy_low);
        end
        check("sat_cnt16", match_cnt, 23);
        check("sat_cnt4", s_match_cnt, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
